iomem_timer: RTL

Memory-mapped prescaled timer/compare peripheral on the PicoSoC `iomem` bus, sitting beside the GPIO register block and decoding its own address window. Counts prescaled clock ticks, raises a sticky match flag when the count equals a programmable compare value, and drives a level interrupt intended for one of the SoC's spare IRQ inputs (`irq_5`). Supports one-shot and auto-reload modes.

---
 rtl/iomem_timer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/iomem_timer.sv
// Prescaled timer/compare peripheral on the PicoSoC iomem bus: sticky match
// flag, level interrupt, one-shot or auto-reload operation.
module iomem_timer #(
    parameter logic [7:0]  BASE_ADDR  = 8'h04,
    parameter int unsigned PRESCALE_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iomem_valid,
    output logic        iomem_ready,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    output logic        irq
);

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned CTRL_W    = 3;
    localparam int unsigned CTRL_EN   = 0;
    localparam int unsigned CTRL_AUTO = 1;
    localparam int unsigned CTRL_IRQ  = 2;

    localparam logic [7:0] OFF_CTRL     = 8'h00;
    localparam logic [7:0] OFF_PRESCALE = 8'h04;
    localparam logic [7:0] OFF_COUNT    = 8'h08;
    localparam logic [7:0] OFF_COMPARE  = 8'h0C;
    localparam logic [7:0] OFF_STATUS   = 8'h10;

    logic [CTRL_W-1:0]     ctrl_q, ctrl_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
    logic [DATA_W-1:0]     count_q, count_d;
    logic [DATA_W-1:0]     compare_q, compare_d;
    logic                  match_q, match_d;
    logic [DATA_W-1:0]     rdata_d;
    logic                  irq_d;

    logic       accept;
    logic       wr_en;
    logic       tick;
    logic       hit;
    logic       status_clr;
    logic [7:0] reg_sel;
    logic       unused_addr;

    // Byte-lane write merge: lanes without a strobe keep their old value.
    function automatic logic [DATA_W-1:0] lane_merge(
        input logic [DATA_W-1:0] old_val,
        input logic [DATA_W-1:0] new_val,
        input logic [3:0]        strb
    );
        logic [DATA_W-1:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                res[i*8 +: 8] = new_val[i*8 +: 8];
            end
        end
        return res;
    endfunction

    assign reg_sel     = iomem_addr[7:0];
    assign unused_addr = ^iomem_addr[23:8];
    assign accept      = iomem_valid && !iomem_ready && (iomem_addr[31:24] == BASE_ADDR);
    assign wr_en       = accept && (iomem_wstrb != 4'b0000);
    assign tick        = ctrl_q[CTRL_EN] && (pcnt_q == prescale_q);
    assign hit         = tick && (count_q == compare_q);
    assign status_clr  = wr_en && (reg_sel == OFF_STATUS) && iomem_wstrb[0] && iomem_wdata[0];

    // Next-state: prescaler/tick update first, then bus writes override.
    always_comb begin
        ctrl_d     = ctrl_q;
        prescale_d = prescale_q;
        pcnt_d     = '0;
        count_d    = count_q;
        compare_d  = compare_q;
        match_d    = match_q;
        rdata_d    = '0;
        irq_d      = 1'b0;

        if (ctrl_q[CTRL_EN] && !tick) begin
            pcnt_d = pcnt_q + PRESCALE_W'(1);
        end

        if (status_clr) begin
            match_d = 1'b0;
        end

        // A set in the same cycle as a clear wins because it is applied last.
        if (tick) begin
            if (hit) begin
                match_d = 1'b1;
                if (ctrl_q[CTRL_AUTO]) begin
                    count_d = '0;
                end else begin
                    ctrl_d[CTRL_EN] = 1'b0;
                end
            end else begin
                count_d = count_q + DATA_W'(1);
            end
        end

        if (wr_en) begin
            case (reg_sel)
                OFF_CTRL: begin
                    ctrl_d = CTRL_W'(lane_merge(DATA_W'(ctrl_d), iomem_wdata, iomem_wstrb));
                    pcnt_d = '0;
                end
                OFF_PRESCALE: begin
                    prescale_d = PRESCALE_W'(lane_merge(DATA_W'(prescale_q), iomem_wdata, iomem_wstrb));
                    pcnt_d     = '0;
                end
                OFF_COUNT: begin
                    count_d = lane_merge(count_q, iomem_wdata, iomem_wstrb);
                    pcnt_d  = '0;
                end
                OFF_COMPARE: begin
                    compare_d = lane_merge(compare_q, iomem_wdata, iomem_wstrb);
                end
                default: begin
                end
            endcase
        end

        // Read data reflects the pre-update register state of the accept cycle.
        if (accept) begin
            case (reg_sel)
                OFF_CTRL:     rdata_d = DATA_W'(ctrl_q);
                OFF_PRESCALE: rdata_d = DATA_W'(prescale_q);
                OFF_COUNT:    rdata_d = count_q;
                OFF_COMPARE:  rdata_d = compare_q;
                OFF_STATUS:   rdata_d = DATA_W'(match_q);
                default:      rdata_d = '0;
            endcase
        end

        irq_d = match_d && ctrl_d[CTRL_IRQ];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q      <= '0;
            prescale_q  <= '0;
            pcnt_q      <= '0;
            count_q     <= '0;
            compare_q   <= '0;
            match_q     <= 1'b0;
            iomem_ready <= 1'b0;
            iomem_rdata <= '0;
            irq         <= 1'b0;
        end else begin
            ctrl_q      <= ctrl_d;
            prescale_q  <= prescale_d;
            pcnt_q      <= pcnt_d;
            count_q     <= count_d;
            compare_q   <= compare_d;
            match_q     <= match_d;
            iomem_ready <= accept;
            iomem_rdata <= rdata_d;
            irq         <= irq_d;
        end
    end

endmodule
